vector_load_assembler: RTL and testbench

- Upstream feeder for the vector register file write port.
- Accepts a load request naming a VRF entry and a beat count, then collects narrow memory beats into one full-width vector.
- Issues a single masked write to the VRF. Lanes not covered by received beats are left untouched in the VRF via the write mask.
- Sits between the memory response path and the VRF write-port arbiter.

---
 rtl/vector_load_assembler_pkg.sv | 35 +++
 rtl/vector_beat_mask_gen.sv | 19 +
 rtl/vector_load_assembler.sv | 110 +++++++++++
 tb/tb_vector_load_assembler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_load_assembler_pkg.sv
// Shared vector-load types and derived sizes.
// Granule 0 of element 0 sits at the vector MSB.
package vector_load_assembler_pkg;

   localparam int NUM_ELEMS           = 8;
   localparam int ELEM_SIZE           = 16;
   localparam int ENABLES_PER_ELEMENT = 4;
   localparam int VRF_SIZE            = 32;
   localparam int BUS_WIDTH           = 32;

   localparam int VEC_WIDTH        = NUM_ELEMS * ELEM_SIZE;
   localparam int SUB_ELEMENT_SIZE = ELEM_SIZE / ENABLES_PER_ELEMENT;
   localparam int BEATS            = VEC_WIDTH / BUS_WIDTH;
   localparam int GRANULES         = NUM_ELEMS * ENABLES_PER_ELEMENT;
   localparam int GRAN_PER_BEAT    = BUS_WIDTH / SUB_ELEMENT_SIZE;
   localparam int ADDR_W           = $clog2(VRF_SIZE);
   localparam int CNT_W            = $clog2(BEATS + 1);

   typedef logic [VEC_WIDTH-1:0] vector_raw_t;
   typedef logic [0:GRANULES-1] flat_mask_t;
   typedef logic [0:ENABLES_PER_ELEMENT-1] elem_mask_t;
   typedef elem_mask_t write_mask_t [0:NUM_ELEMS-1];

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

   // A zero or oversized beat count means a full vector.
   function automatic logic [CNT_W-1:0] norm_beats(
      input logic [CNT_W-1:0] n
   );
      if (n == '0 || n > CNT_W'(BEATS))
         return CNT_W'(BEATS);
      return n;
   endfunction

endpackage

// File: rtl/vector_beat_mask_gen.sv
// Beat index to granule-enable contribution.
// Beat 0 covers the granules at the vector MSB.
module vector_beat_mask_gen
   import vector_load_assembler_pkg::*;
(
   input  logic [CNT_W-1:0] beat_idx,
   output flat_mask_t       mask
);

   // Set every granule that falls inside the beat's bit range.
   always_comb begin
      mask = '0;
      for (int i = 0; i < GRANULES; i++) begin
         if (i / GRAN_PER_BEAT == int'(beat_idx))
            mask[i] = 1'b1;
      end
   end

endmodule

// File: rtl/vector_load_assembler.sv
// Collects memory beats into one vector and
// issues a single masked VRF write.
module vector_load_assembler
   import vector_load_assembler_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [CNT_W-1:0]     req_beats,
   input  logic                 beat_valid,
   output logic                 beat_ready,
   input  logic [BUS_WIDTH-1:0] beat_data,
   output logic                 vrf_en,
   output logic                 vrf_we,
   input  logic                 vrf_gnt,
   output logic [ADDR_W-1:0]    vrf_addr,
   output write_mask_t          vrf_write_mask,
   output logic [VEC_WIDTH-1:0] vrf_data_w,
   output logic                 busy,
   output logic                 done
);

   state_t        state, state_nx;
   logic [CNT_W-1:0]  cnt, beats_r;
   logic [ADDR_W-1:0] addr_r;
   vector_raw_t   data_r;
   flat_mask_t    mask_r, beat_mask;
   logic          done_r;
   logic          accept, take_beat, last_beat;

   assign accept    = state == IDLE && req_valid && !flush;
   assign take_beat = state == COLLECT && beat_valid && !flush;
   assign last_beat = take_beat && (cnt + CNT_W'(1) == beats_r);

   vector_beat_mask_gen u_mask_gen (
      .beat_idx (cnt),
      .mask     (beat_mask)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state: grant wins over flush in WRITE.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = COLLECT;
         COLLECT: begin
            if (flush)          state_nx = IDLE;
            else if (last_beat) state_nx = WRITE;
         end
         WRITE:   if (vrf_gnt || flush) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request latch, beat assembly and done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         beats_r <= '0;
         addr_r  <= '0;
         data_r  <= '0;
         mask_r  <= '0;
         done_r  <= 1'b0;
      end else begin
         done_r <= state == WRITE && vrf_gnt;
         if (accept) begin
            addr_r  <= req_addr;
            beats_r <= norm_beats(req_beats);
            cnt     <= '0;
            data_r  <= '0;
            mask_r  <= '0;
         end
         if (take_beat) begin
            cnt    <= cnt + CNT_W'(1);
            mask_r <= mask_r | beat_mask;
            for (int k = 0; k < BEATS; k++) begin
               if (cnt == CNT_W'(k))
                  data_r[VEC_WIDTH-1-k*BUS_WIDTH -: BUS_WIDTH] <= beat_data;
            end
         end
      end
   end

   // Unflatten the granule mask into per-element enables.
   always_comb begin
      vrf_write_mask = '{default: '0};
      for (int e = 0; e < NUM_ELEMS; e++) begin
         for (int g = 0; g < ENABLES_PER_ELEMENT; g++)
            vrf_write_mask[e][g] = mask_r[e*ENABLES_PER_ELEMENT+g];
      end
   end

   assign req_ready  = state == IDLE;
   assign beat_ready = state == COLLECT;
   assign vrf_en     = state == WRITE;
   assign vrf_we     = state == WRITE;
   assign busy       = state != IDLE;
   assign done       = done_r;
   assign vrf_addr   = addr_r;
   assign vrf_data_w = data_r;

endmodule

// File: tb/tb_vector_load_assembler.sv
// Self-checking bench for vector_load_assembler:
// directed scenarios plus randomized traffic against a model.
module tb_vector_load_assembler;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         flush = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [4:0]   req_addr = '0;
   logic [2:0]   req_beats = '0;
   logic         beat_valid = 1'b0;
   logic         beat_ready;
   logic [31:0]  beat_data = '0;
   logic         vrf_en, vrf_we;
   logic         vrf_gnt = 1'b0;
   logic [4:0]   vrf_addr;
   logic [0:3]   vrf_write_mask [0:7];
   logic [127:0] vrf_data_w;
   logic         busy, done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vector_load_assembler dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_beats      (req_beats),
      .beat_valid     (beat_valid),
      .beat_ready     (beat_ready),
      .beat_data      (beat_data),
      .vrf_en         (vrf_en),
      .vrf_we         (vrf_we),
      .vrf_gnt        (vrf_gnt),
      .vrf_addr       (vrf_addr),
      .vrf_write_mask (vrf_write_mask),
      .vrf_data_w     (vrf_data_w),
      .busy           (busy),
      .done           (done)
   );

   // Mask flattened with element 0 / granule 0 at bit 31.
   logic [31:0] dut_mask;
   always_comb begin
      dut_mask = '0;
      for (int e = 0; e < 8; e++)
         for (int g = 0; g < 4; g++)
            dut_mask[31-(e*4+g)] = vrf_write_mask[e][g];
   end

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: phase 0 idle, 1 collecting, 2 writing.
   int          m_phase = 0;
   logic [4:0]  m_addr = '0;
   int          m_need = 0;
   logic [31:0] m_q[$];
   logic        m_done = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase = 0;
         m_done = 1'b0;
         m_q.delete();
      end else begin
         m_done = 1'b0;
         case (m_phase)
            0: if (req_valid && !flush) begin
               m_addr = req_addr;
               m_need = (req_beats == 0 || req_beats > 4) ? 4 : int'(req_beats);
               m_q.delete();
               m_phase = 1;
            end
            1: if (flush) m_phase = 0;
               else if (beat_valid) begin
                  m_q.push_back(beat_data);
                  if (m_q.size() == m_need) m_phase = 2;
               end
            default: if (vrf_gnt) begin
               m_phase = 0;
               m_done = 1'b1;
            end else if (flush) m_phase = 0;
         endcase
      end
   end

   // Every-cycle comparison against the model.
   logic [127:0] ev;
   logic [31:0]  em;
   always @(negedge clk) begin
      if (!reset) begin
         chk("ctrl",
             {122'd0, req_ready, beat_ready, vrf_en, vrf_we, busy, done},
             {122'd0, m_phase == 0, m_phase == 1, m_phase == 2,
              m_phase == 2, m_phase != 0, m_done});
         if (m_phase == 2) begin
            ev = '0;
            for (int k = 0; k < 4; k++)
               ev = {ev[95:0], (k < m_q.size()) ? m_q[k] : 32'h0};
            em = ~(32'hFFFF_FFFF >> (8 * m_q.size()));
            chk("m_addr", {123'd0, vrf_addr}, {123'd0, m_addr});
            chk("m_data", vrf_data_w, ev);
            chk("m_mask", {96'd0, dut_mask}, {96'd0, em});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [4:0] a, input logic [2:0] b);
      req_valid = 1'b1;
      req_addr = a;
      req_beats = b;
      step();
      req_valid = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d);
      beat_valid = 1'b1;
      beat_data = d;
      step();
      beat_valid = 1'b0;
   endtask

   logic [127:0] snap_d;
   logic [31:0]  snap_m;

   initial begin
      #12;
      chk("rst_ready", {127'd0, req_ready}, 128'd1);
      chk("rst_ctrl", {123'd0, beat_ready, vrf_en, vrf_we, busy, done}, 128'd0);
      chk("rst_data", vrf_data_w, 128'd0);
      chk("rst_mask", {96'd0, dut_mask}, 128'd0);
      #10 reset = 1'b0;
      step();

      // Full load, grant held high.
      vrf_gnt = 1'b1;
      req(5'd5, 3'd4);
      beat(32'h11111111);
      beat(32'h22222222);
      beat(32'h33333333);
      beat(32'h44444444);
      chk("full_en", {127'd0, vrf_en}, 128'd1);
      chk("full_done0", {127'd0, done}, 128'd0);
      chk("full_addr", {123'd0, vrf_addr}, 128'd5);
      chk("full_data", vrf_data_w,
          128'h11111111222222223333333344444444);
      chk("full_mask", {96'd0, dut_mask}, 128'hFFFFFFFF);
      step();
      chk("full_done", {126'd0, done, req_ready}, 128'd3);

      // Partial load with a 3-cycle grant stall.
      vrf_gnt = 1'b0;
      req(5'd31, 3'd2);
      beat(32'hAAAAAAAA);
      beat(32'hBBBBBBBB);
      snap_d = vrf_data_w;
      snap_m = dut_mask;
      chk("part_data", vrf_data_w, {64'hAAAAAAAABBBBBBBB, 64'h0});
      chk("part_mask", {96'd0, dut_mask}, 128'hFFFF0000);
      chk("part_addr", {123'd0, vrf_addr}, 128'd31);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_ctl", {125'd0, vrf_en, beat_ready, done}, 128'd4);
         chk("stall_dat", vrf_data_w, snap_d);
         chk("stall_msk", {96'd0, dut_mask}, {96'd0, snap_m});
      end
      vrf_gnt = 1'b1;
      step();
      chk("stall_done", {127'd0, done}, 128'd1);

      // Flush after one beat; zero beat count means full.
      req(5'd7, 3'd0);
      beat(32'hDEADBEEF);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_idle", {126'd0, req_ready, busy}, 128'd2);
      req(5'd8, 3'd4);
      beat(32'h1);
      beat(32'h2);
      beat(32'h3);
      beat(32'h4);
      chk("clean_data", vrf_data_w,
          128'h00000001000000020000000300000004);
      step();

      // Stray beats in IDLE, then gapped beats.
      beat_valid = 1'b1;
      beat_data = 32'hFFFFFFFF;
      step();
      step();
      beat_valid = 1'b0;
      chk("stray_idle", {127'd0, busy}, 128'd0);
      vrf_gnt = 1'b0;
      req(5'd3, 3'd3);
      for (int i = 0; i < 6; i++) begin
         beat_valid = (i % 2 == 1);
         beat_data = 32'hC0DE0000 + i;
         step();
      end
      beat_valid = 1'b0;
      chk("gap_data", vrf_data_w,
          {32'hC0DE0001, 32'hC0DE0003, 32'hC0DE0005, 32'h0});
      chk("gap_mask", {96'd0, dut_mask}, 128'hFFFFFF00);

      // Async reset between edges while in WRITE.
      #2 reset = 1'b1;
      #1;
      chk("areset", {124'd0, vrf_en, vrf_we, busy, req_ready}, 128'd1);
      #3 reset = 1'b0;
      vrf_gnt = 1'b1;
      step();
      chk("areset_done", {127'd0, done}, 128'd0);
      chk("areset_data", vrf_data_w, 128'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         req_valid = $urandom_range(1, 0) == 1;
         req_addr = 5'($urandom);
         req_beats = 3'($urandom);
         beat_valid = $urandom_range(9, 0) < 6;
         beat_data = $urandom;
         vrf_gnt = $urandom_range(1, 0) == 1;
         flush = $urandom_range(19, 0) == 0;
         step();
      end
      req_valid = 1'b0;
      beat_valid = 1'b0;
      flush = 1'b0;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
